// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus words, RAM handshake states, arbiter owner ids
// and arbiter FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        D0   = 3'd1,
        D1   = 3'd2,
        I0   = 3'd3,
        I1   = 3'd4
    } req_id_t;

    typedef enum logic {
        ARB = 1'b0,
        ACT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: the pointed-to requester wins a tie, otherwise
// the lone requester wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    assign gnt_valid_o = |req_i;
    assign gnt_idx_o   = req_i[ptr_i] ? ptr_i : ~ptr_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between the icache/dcache of two cores: dcache over icache,
// round robin per class, bounded icache starvation, block-locked dcache grants.
module mem_bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int BLOCK_WORDS  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [1:0]   iREN,
    input  word_t [1:0]  iaddr,
    output logic [1:0]   iwait,
    output word_t [1:0]  iload,
    input  logic [1:0]   dREN,
    input  logic [1:0]   dWEN,
    input  word_t [1:0]  daddr,
    input  word_t [1:0]  dstore,
    output logic [1:0]   dwait,
    output word_t [1:0]  dload,
    output logic         ramREN,
    output logic         ramWEN,
    output word_t        ramaddr,
    output word_t        ramstore,
    input  word_t        ramload,
    input  logic [1:0]   ramstate,
    output logic         ram_err,
    output logic [2:0]   grant_id
);

    localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(BLOCK_WORDS - 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    arb_state_t     state_q, state_d;
    req_id_t        grant_q, grant_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
    logic           d_ptr_q, d_ptr_d;
    logic           i_ptr_q, i_ptr_d;
    logic           ram_err_q, ram_err_d;

    logic [1:0] d_act;
    logic       d_valid, d_idx, i_valid, i_idx;
    logic       starved, pick_i, pick_d;
    req_id_t    winner;
    ramstate_t  rstate;
    logic       own_d, own_core, own_act, complete;

    assign d_act  = dREN | dWEN;
    assign rstate = ramstate_t'(ramstate);

    rr_pick2 u_pick_d (
        .req_i       (d_act),
        .ptr_i       (d_ptr_q),
        .gnt_valid_o (d_valid),
        .gnt_idx_o   (d_idx)
    );

    rr_pick2 u_pick_i (
        .req_i       (iREN),
        .ptr_i       (i_ptr_q),
        .gnt_valid_o (i_valid),
        .gnt_idx_o   (i_idx)
    );

    // Starvation overrides dcache priority only while an icache is actually waiting.
    assign starved = (starve_cnt_q >= STARVE_MAX) && i_valid;
    assign pick_i  = starved || (!d_valid && i_valid);
    assign pick_d  = d_valid && !starved;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        winner = NONE;
        if (pick_i) begin
            winner = i_idx ? I1 : I0;
        end else if (pick_d) begin
            winner = d_idx ? D1 : D0;
        end
    end

    assign own_d    = (grant_q == D0) || (grant_q == D1);
    assign own_core = (grant_q == D1) || (grant_q == I1);
    assign own_act  = own_d ? d_act[own_core] : iREN[own_core];
    assign complete = (state_q == ACT) && own_act && (rstate == ACCESS);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ARB;
            grant_q      <= NONE;
            word_cnt_q   <= '0;
            starve_cnt_q <= '0;
            d_ptr_q      <= 1'b0;
            i_ptr_q      <= 1'b0;
            ram_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            word_cnt_q   <= word_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            d_ptr_q      <= d_ptr_d;
            i_ptr_q      <= i_ptr_d;
            ram_err_q    <= ram_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        word_cnt_d   = word_cnt_q;
        starve_cnt_d = starve_cnt_q;
        d_ptr_d      = d_ptr_q;
        i_ptr_d      = i_ptr_q;
        ram_err_d    = ram_err_q | (rstate == ERROR);
        case (state_q)
            ARB: begin
                if (winner != NONE) begin
                    state_d    = ACT;
                    grant_d    = winner;
                    word_cnt_d = '0;
                    if (pick_i) begin
                        i_ptr_d      = ~i_ptr_q;
                        starve_cnt_d = '0;
                    end else begin
                        d_ptr_d = ~d_ptr_q;
                        if (i_valid && (starve_cnt_q != STARVE_MAX)) begin
                            starve_cnt_d = starve_cnt_q + SCW'(1);
                        end
                    end
                end
            end
            ACT: begin
                // A dcache owner keeps the bus until its last block word completes.
                if (!own_act || (complete && (!own_d || (word_cnt_q == LAST_WORD)))) begin
                    state_d    = ARB;
                    grant_d    = NONE;
                    word_cnt_d = '0;
                end else if (complete) begin
                    word_cnt_d = word_cnt_q + WCW'(1);
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 2'b11;
        dwait    = 2'b11;
        if (state_q == ACT) begin
            if (own_d) begin
                ramWEN   = dWEN[own_core];
                ramREN   = dREN[own_core] & ~dWEN[own_core];
                ramaddr  = daddr[own_core];
                ramstore = dstore[own_core];
                if (complete) begin
                    dwait[own_core] = 1'b0;
                end
            end else begin
                ramREN  = iREN[own_core];
                ramaddr = iaddr[own_core];
                if (complete) begin
                    iwait[own_core] = 1'b0;
                end
            end
        end
    end

    assign iload    = {ramload, ramload};
    assign dload    = {ramload, ramload};
    assign ram_err  = ram_err_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with hand-computed expectations,
// then randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_mem_bus_arbiter;

    localparam int BW = 2;
    localparam int SL = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       iREN, dREN, dWEN;
    logic [1:0][31:0] iaddr, daddr, dstore, iload, dload;
    logic [1:0]       iwait, dwait;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;
    logic             ram_err;
    logic [2:0]       grant_id;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter #(.BLOCK_WORDS(BW), .STARVE_LIMIT(SL)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .ram_err  (ram_err),
        .grant_id (grant_id)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Behavioural model. Owner: -1 idle, 0 D0, 1 D1, 2 I0, 3 I1 (grant_id = owner+1).
    int m_owner = -1, m_words = 0, m_streak = 0, m_pref_d = 0, m_pref_i = 0;
    bit m_err = 0;
    int n_owner = -1, n_words = 0, n_streak = 0, n_pref_d = 0, n_pref_i = 0;
    bit n_err = 0;

    function automatic int pick(input logic [1:0] req, input int pref);
        if (req[pref]) return pref;
        return req[0] ? 0 : 1;
    endfunction

    always @(negedge CLK) begin : compare
        int          c;
        bit          is_d, act, done, any_d, any_i;
        logic [1:0]  e_iw, e_dw;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        e_iw = 2'b11; e_dw = 2'b11; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = '0; e_store = '0; act = 0; done = 0; c = 0; is_d = 0;
        if (m_owner >= 0) begin
            c    = m_owner % 2;
            is_d = (m_owner < 2);
            act  = is_d ? (dREN[c] | dWEN[c]) : iREN[c];
            done = act && (ramstate == 2'd2);
            if (is_d) begin
                e_wen   = dWEN[c];
                e_ren   = dREN[c] && !dWEN[c];
                e_addr  = daddr[c];
                e_store = dstore[c];
                if (done) e_dw[c] = 1'b0;
            end else begin
                e_ren  = iREN[c];
                e_addr = iaddr[c];
                if (done) e_iw[c] = 1'b0;
            end
        end
        check("grant_id", grant_id, (m_owner < 0) ? 0 : m_owner + 1);
        check("iwait", iwait, e_iw);
        check("dwait", dwait, e_dw);
        check("ramREN", ramREN, e_ren);
        check("ramWEN", ramWEN, e_wen);
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("ram_err", ram_err, m_err);
        if (done && is_d) check("dload", dload[c], ramload);
        if (done && !is_d) check("iload", iload[c], ramload);

        n_owner = m_owner; n_words = m_words; n_streak = m_streak;
        n_pref_d = m_pref_d; n_pref_i = m_pref_i;
        n_err = m_err || (ramstate == 2'd3);
        any_d = |(dREN | dWEN);
        any_i = |iREN;
        if (m_owner < 0) begin
            n_words = 0;
            if (any_i && (m_streak >= SL || !any_d)) begin
                n_owner  = 2 + pick(iREN, m_pref_i);
                n_pref_i = 1 - m_pref_i;
                n_streak = 0;
            end else if (any_d) begin
                n_owner  = pick(dREN | dWEN, m_pref_d);
                n_pref_d = 1 - m_pref_d;
                if (any_i) n_streak = (m_streak + 1 > SL) ? SL : m_streak + 1;
            end
        end else if (!act) begin
            n_owner = -1;
            n_words = 0;
        end else if (done) begin
            if (!is_d || m_words + 1 == BW) begin
                n_owner = -1;
                n_words = 0;
            end else begin
                n_words = m_words + 1;
            end
        end
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner <= -1; m_words <= 0; m_streak <= 0;
            m_pref_d <= 0; m_pref_i <= 0; m_err <= 0;
        end else begin
            m_owner <= n_owner; m_words <= n_words; m_streak <= n_streak;
            m_pref_d <= n_pref_d; m_pref_i <= n_pref_i; m_err <= n_err;
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    int c_exp [10] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0};
    int d_exp [28] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0, 3,
                       0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0, 3};

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic [1:0] d_on, d_wr, i_on, dw, iw;
        int         d_cnt [2];
        int         r;
        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;

        // Reset state
        neg();
        check("rst grant_id", grant_id, 0);
        check("rst iwait", iwait, 2'b11);
        check("rst dwait", dwait, 2'b11);
        check("rst ramREN", ramREN, 0);
        check("rst ramWEN", ramWEN, 0);
        check("rst ramaddr", ramaddr, 0);
        check("rst ram_err", ram_err, 0);
        cyc(); nRST = 1'b1;

        // Single D0 read at 0x100, ACCESS on its second cycle, then drop
        cyc(); dREN = 2'b01; daddr[0] = 32'h100; ramstate = 2'd1;
        neg(); check("A grant idle", grant_id, 0); check("A ren idle", ramREN, 0);
        cyc(); ramstate = 2'd2; ramload = 32'hCAFE_0001;
        neg(); check("A grant D0", grant_id, 1); check("A ramREN", ramREN, 1);
        check("A ramaddr", ramaddr, 32'h100); check("A dwait", dwait, 2'b10);
        check("A dload", dload[0], 32'hCAFE_0001);
        cyc(); ramstate = 2'd1;
        neg(); check("A dwait held", dwait, 2'b11); check("A grant held", grant_id, 1);
        cyc(); dREN = 2'b00;
        neg(); check("A drop ramREN", ramREN, 0);
        cyc();
        neg(); check("A back to arb", grant_id, 0);

        // D0 two-word writeback with I1 requesting alongside
        cyc(); dWEN = 2'b01; daddr[0] = 32'h200; dstore[0] = 32'h11;
        iREN = 2'b10; iaddr[1] = 32'h400; ramstate = 2'd1;
        neg(); check("B grant idle", grant_id, 0);
        cyc(); ramstate = 2'd2; ramload = 32'hAAAA_0001;
        neg(); check("B w0 grant", grant_id, 1); check("B w0 ramWEN", ramWEN, 1);
        check("B w0 ramREN", ramREN, 0); check("B w0 addr", ramaddr, 32'h200);
        check("B w0 store", ramstore, 32'h11); check("B w0 dwait", dwait, 2'b10);
        check("B w0 iwait", iwait, 2'b11);
        cyc(); daddr[0] = 32'h204; dstore[0] = 32'h22;
        neg(); check("B w1 grant", grant_id, 1); check("B w1 addr", ramaddr, 32'h204);
        check("B w1 store", ramstore, 32'h22); check("B w1 dwait", dwait, 2'b10);
        cyc(); dWEN = 2'b00; ramstate = 2'd1;
        neg(); check("B gap grant", grant_id, 0); check("B gap ramWEN", ramWEN, 0);
        check("B gap iwait", iwait, 2'b11);
        cyc(); ramstate = 2'd2;
        neg(); check("B I1 grant", grant_id, 4); check("B I1 addr", ramaddr, 32'h400);
        check("B I1 iwait", iwait, 2'b01);
        cyc(); iREN = 2'b00; ramstate = 2'd0;
        neg(); check("B done", grant_id, 0);

        // D0 and D1 both streaming: grants alternate per block
        cyc(); dREN = 2'b11; ramstate = 2'd2;
        for (int k = 0; k < 10; k++) begin
            neg(); check("C grant seq", grant_id, c_exp[k]);
            cyc();
        end
        dREN = 2'b00;
        neg(); cyc();

        // Dcache saturates the bus while I0 waits: I0 after exactly SL dcache grants
        dREN = 2'b11; iREN = 2'b01; iaddr[0] = 32'h800;
        for (int k = 0; k < 28; k++) begin
            neg(); check("D grant seq", grant_id, d_exp[k]);
            if (k == 13 || k == 27) check("D I0 iwait", iwait, 2'b10);
            cyc();
        end
        dREN = 2'b00; iREN = 2'b00;
        neg(); cyc();

        // ERROR responses hold the request and set the sticky flag
        dREN = 2'b10; daddr[1] = 32'h300; ramstate = 2'd1;
        neg(); check("E err before", ram_err, 0);
        cyc(); ramstate = 2'd3;
        neg(); check("E grant D1", grant_id, 2); check("E dwait e0", dwait, 2'b11);
        cyc();
        neg(); check("E dwait e1", dwait, 2'b11); check("E err set", ram_err, 1);
        cyc();
        neg(); check("E dwait e2", dwait, 2'b11); check("E addr held", ramaddr, 32'h300);
        cyc(); ramstate = 2'd2; ramload = 32'hBEEF_0003;
        neg(); check("E complete", dwait, 2'b01); check("E dload", dload[1], 32'hBEEF_0003);
        cyc(); ramstate = 2'd1;
        neg(); check("E err sticky", ram_err, 1); check("E dwait after", dwait, 2'b11);
        cyc(); dREN = 2'b00;
        neg(); cyc();

        // Reset after word 1 of 2; the re-requested block restarts at word 0
        dREN = 2'b01; daddr[0] = 32'h500; ramstate = 2'd2;
        neg(); check("F grant idle", grant_id, 0);
        cyc();
        neg(); check("F w0 dwait", dwait, 2'b10);
        cyc(); nRST = 1'b0;
        neg(); check("F rst grant", grant_id, 0); check("F rst dwait", dwait, 2'b11);
        check("F rst iwait", iwait, 2'b11); check("F rst ramREN", ramREN, 0);
        check("F rst ramWEN", ramWEN, 0); check("F rst addr", ramaddr, 0);
        check("F rst err", ram_err, 0);
        cyc(); nRST = 1'b1;
        neg(); check("F rearb", grant_id, 0);
        cyc();
        neg(); check("F r0 grant", grant_id, 1); check("F r0 dwait", dwait, 2'b10);
        cyc();
        neg(); check("F r1 grant", grant_id, 1); check("F r1 dwait", dwait, 2'b10);
        cyc(); dREN = 2'b00;
        neg(); check("F end", grant_id, 0);

        // Randomized traffic; the compare process checks every cycle
        d_on = '0; d_wr = '0; i_on = '0; d_cnt[0] = 0; d_cnt[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            neg(); dw = dwait; iw = iwait;
            cyc();
            if (!nRST) begin
                nRST = 1'b1; d_on = '0; i_on = '0;
            end else if ($urandom_range(0, 499) == 0) begin
                nRST = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                if (d_on[c]) begin
                    if (!dw[c]) d_cnt[c]++;
                    if (d_cnt[c] >= BW || $urandom_range(0, 29) == 0) d_on[c] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    d_on[c] = 1'b1; d_cnt[c] = 0; d_wr[c] = 1'($urandom_range(0, 1));
                end
                if (i_on[c]) begin
                    if (!iw[c] || $urandom_range(0, 29) == 0) i_on[c] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    i_on[c] = 1'b1;
                end
                daddr[c]  = $urandom;
                dstore[c] = $urandom;
                iaddr[c]  = $urandom;
                dWEN[c]   = d_on[c] & d_wr[c];
                dREN[c]   = d_on[c] & (~d_wr[c] | ($urandom_range(0, 3) == 0));
            end
            iREN    = i_on;
            ramload = $urandom;
            r = $urandom_range(0, 99);
            ramstate = (r < 10) ? 2'd0 : (r < 40) ? 2'd1 : (r < 97) ? 2'd2 : 2'd3;
        end
        neg();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
